// File: rtl/hack_ps2_tx.sv
// Device-side PS/2 set-2 transmitter: serialises one key event as [E0] [F0] code frames.
// Optional host-inhibit handling is compiled in with `define PS2_TX_INHIBIT_EN.
module hack_ps2_tx #(
    parameter int CLK_HALF = 4,
    parameter int GAP      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key_code,
    input  logic       key_ext,
    input  logic       key_rel,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       done,
    output logic       ps2_clk,
    output logic       ps2_data,
    input  logic       ps2_clk_in
);

    localparam int PMAX = (CLK_HALF > GAP) ? CLK_HALF : GAP;
    localparam int PW   = $clog2(PMAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIT_HI,
        S_BIT_LO,
        S_GAP
`ifdef PS2_TX_INHIBIT_EN
        , S_WAIT,
        S_ABORT
`endif
    } state_t;

    state_t         state;
    logic [PW-1:0]  phase;
    logic [3:0]     bit_cnt;
    logic [1:0]     byte_idx;
    logic [7:0]     code_q;
    logic           ext_q;
    logic           rel_q;
    logic [7:0]     cur_byte;
    logic           last_byte;

    // Byte k of the sequence is derived from the latched flags rather than stored.
    function automatic logic [7:0] byte_at(input logic [1:0] idx, input logic e,
                                           input logic r, input logic [7:0] c);
        byte_at = c;
        if (e && idx == 2'd0)
            byte_at = 8'hE0;
        else if (r && idx == {1'b0, e})
            byte_at = 8'hF0;
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] n);
        logic [2:0] j;
        j = 3'(n - 4'd1);
        case (n)
            4'd0:    frame_bit = 1'b0;
            4'd9:    frame_bit = ~^b;
            4'd10:   frame_bit = 1'b1;
            default: frame_bit = b[j];
        endcase
    endfunction

    assign cur_byte  = byte_at(byte_idx, ext_q, rel_q, code_q);
    assign last_byte = (byte_idx == ({1'b0, ext_q} + {1'b0, rel_q}));

`ifdef PS2_TX_INHIBIT_EN
    logic clk_meta;
    logic clk_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk_in;
            clk_sync <= clk_meta;
        end
    end
`else
    logic unused_clk_in;
    assign unused_clk_in = ps2_clk_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            phase     <= '0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            code_q    <= '0;
            ext_q     <= 1'b0;
            rel_q     <= 1'b0;
            key_ready <= 1'b1;
            done      <= 1'b0;
            ps2_clk   <= 1'b1;
            ps2_data  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (key_valid) begin
                        code_q    <= key_code;
                        ext_q     <= key_ext;
                        rel_q     <= key_rel;
                        key_ready <= 1'b0;
                        byte_idx  <= '0;
                        bit_cnt   <= '0;
                        phase     <= '0;
`ifdef PS2_TX_INHIBIT_EN
                        if (!clk_sync)
                            state <= S_WAIT;
                        else
`endif
                        begin
                            state    <= S_BIT_HI;
                            ps2_data <= 1'b0;
                        end
                    end
                end
                S_BIT_HI: begin
`ifdef PS2_TX_INHIBIT_EN
                    if (!clk_sync && bit_cnt != 4'd10) begin
                        state    <= S_ABORT;
                        phase    <= '0;
                        ps2_clk  <= 1'b1;
                        ps2_data <= 1'b1;
                    end else
`endif
                    if (phase == PW'(CLK_HALF - 1)) begin
                        state   <= S_BIT_LO;
                        phase   <= '0;
                        ps2_clk <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_BIT_LO: begin
                    if (phase == PW'(CLK_HALF - 1)) begin
                        phase   <= '0;
                        ps2_clk <= 1'b1;
                        if (bit_cnt < 4'd10) begin
                            state    <= S_BIT_HI;
                            bit_cnt  <= bit_cnt + 4'd1;
                            ps2_data <= frame_bit(cur_byte, bit_cnt + 4'd1);
                        end else begin
                            state    <= S_GAP;
                            ps2_data <= 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_GAP: begin
                    if (phase == PW'(GAP - 1)) begin
                        phase <= '0;
                        if (!last_byte) begin
                            byte_idx <= byte_idx + 2'd1;
                            bit_cnt  <= '0;
`ifdef PS2_TX_INHIBIT_EN
                            if (!clk_sync)
                                state <= S_WAIT;
                            else
`endif
                            begin
                                state    <= S_BIT_HI;
                                ps2_data <= 1'b0;
                            end
                        end else begin
                            state     <= S_IDLE;
                            done      <= 1'b1;
                            key_ready <= 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
`ifdef PS2_TX_INHIBIT_EN
                S_WAIT: begin
                    if (clk_sync) begin
                        state    <= S_BIT_HI;
                        phase    <= '0;
                        ps2_data <= 1'b0;
                    end
                end
                // Retry restarts the interrupted byte only; earlier bytes stay sent.
                S_ABORT: begin
                    if (!clk_sync) begin
                        phase <= '0;
                    end else if (phase == PW'(GAP - 1)) begin
                        state    <= S_BIT_HI;
                        phase    <= '0;
                        bit_cnt  <= '0;
                        ps2_data <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_ps2_tx.sv
// Directed self-checking bench for hack_ps2_tx (CLK_HALF=4, GAP=8, byte slot 96 cycles).
module tb_hack_ps2_tx;

    localparam int CH = 4;
    localparam int GP = 8;
    localparam int B  = 22 * CH + GP;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] key_code = 8'h00;
    logic       key_ext = 1'b0;
    logic       key_rel = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic       done;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_in = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    hack_ps2_tx #(.CLK_HALF(CH), .GAP(GP)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_rel    (key_rel),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .done       (done),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_clk_in (ps2_clk_in)
    );

    always #5 clk = ~clk;

    task automatic drive_event(input logic [7:0] c, input logic e, input logic r);
        key_code  = c;
        key_ext   = e;
        key_rel   = r;
        key_valid = 1'b1;
    endtask

    // Expected waveform from hand-supplied bytes and parity bits; cycle n counts from the accept edge.
    task automatic check_frames(input string name, input int nb,
                                input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic p0, input logic p1, input logic p2,
                                input logic noise, input logic chain,
                                input logic [7:0] nc, input logic ne, input logic nr);
        logic [7:0]  bytes [3];
        logic        par   [3];
        logic [10:0] cap   [3];
        logic [10:0] frame;
        logic [3:0]  exp_v;
        logic [3:0]  got_v;
        logic        prev_clk;
        logic [7:0]  orig_code;
        int          falls;
        int          first_fall;
        int          total;
        int          k;
        int          r;
        int          i;
        int          ph;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        par[0] = p0;   par[1] = p1;   par[2] = p2;
        for (int j = 0; j < 3; j++) cap[j] = '0;
        prev_clk   = 1'b1;
        falls      = 0;
        first_fall = -1;
        orig_code  = key_code;
        total      = chain ? nb * B + 1 : nb * B + 2;
        for (int n = 1; n <= total; n++) begin
            @(negedge clk);
            if (n == nb * B + 1) begin
                exp_v = 4'b1111;
            end else if (n == nb * B + 2) begin
                exp_v = 4'b1101;
            end else begin
                k = (n - 1) / B;
                r = (n - 1) % B;
                if (r < 22 * CH) begin
                    i     = r / (2 * CH);
                    ph    = r % (2 * CH);
                    frame = {1'b1, par[k], bytes[k], 1'b0};
                    exp_v = {(ph < CH), frame[i], 1'b0, 1'b0};
                end else begin
                    exp_v = 4'b1100;
                end
            end
            got_v = {ps2_clk, ps2_data, done, key_ready};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d: clk/data/done/ready got %b expected %b", name, n, got_v, exp_v);
            end
            if (prev_clk && !ps2_clk) begin
                if (first_fall < 0) first_fall = n;
                if (falls < 33) cap[falls / 11][falls % 11] = ps2_data;
                falls++;
            end
            prev_clk = ps2_clk;
            if (n == 1) key_valid = 1'b0;
            if (noise && (n == 10 || n == 30 || n == 50)) begin
                key_valid = 1'b1;
                key_code  = 8'h11;
            end else if (noise && (n == 11 || n == 31 || n == 51)) begin
                key_valid = 1'b0;
                key_code  = orig_code;
            end
            if (chain && n == nb * B + 1) drive_event(nc, ne, nr);
        end
        n_checks++;
        if (falls != 11 * nb) begin
            n_fail++;
            $display("FAIL %s_fall_count: got %0d expected %0d", name, falls, 11 * nb);
        end
        n_checks++;
        if (first_fall != CH + 1) begin
            n_fail++;
            $display("FAIL %s_first_fall: got cycle %0d expected %0d", name, first_fall, CH + 1);
        end
        for (int j = 0; j < nb; j++) begin
            frame = {1'b1, par[j], bytes[j], 1'b0};
            n_checks++;
            if (cap[j] !== frame) begin
                n_fail++;
                $display("FAIL %s_frame%0d: got %b expected %b", name, j, cap[j], frame);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ps2_clk, ps2_data, done, key_ready} !== 4'b1101) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 1101", {ps2_clk, ps2_data, done, key_ready});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ps2_clk, ps2_data, done, key_ready} !== 4'b1101) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 1101", {ps2_clk, ps2_data, done, key_ready});
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        drive_event(8'h1C, 1'b0, 1'b0);
        check_frames("single_1c", 1, 8'h1C, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_ext_rel();
        @(negedge clk);
        drive_event(8'h75, 1'b1, 1'b1);
        check_frames("ext_rel_75", 3, 8'hE0, 8'hF0, 8'h75, 1'b0, 1'b1, 1'b0,
                     1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_busy();
        @(negedge clk);
        drive_event(8'h75, 1'b1, 1'b1);
        check_frames("busy_ignore", 3, 8'hE0, 8'hF0, 8'h75, 1'b0, 1'b1, 1'b0,
                     1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        drive_event(8'h1C, 1'b0, 1'b0);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) key_valid = 1'b0;
        end
        // cycle 40 is the low phase of bit 4 (d3 of 0x1C = 1)
        n_checks++;
        if ({ps2_clk, ps2_data} !== 2'b01) begin
            n_fail++;
            $display("FAIL midframe_before_reset: clk/data got %b expected 01", {ps2_clk, ps2_data});
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({ps2_clk, ps2_data, done, key_ready} !== 4'b1101) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 1101", {ps2_clk, ps2_data, done, key_ready});
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            n_checks++;
            if ({ps2_clk, ps2_data, done, key_ready} !== 4'b1101) begin
                n_fail++;
                $display("FAIL reset_hold%0d: got %b expected 1101", n, {ps2_clk, ps2_data, done, key_ready});
            end
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ps2_clk, ps2_data, done, key_ready} !== 4'b1101) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected 1101", {ps2_clk, ps2_data, done, key_ready});
        end
        drive_event(8'h1C, 1'b0, 1'b0);
        check_frames("after_reset_1c", 1, 8'h1C, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_event(8'h1C, 1'b0, 1'b0);
        check_frames("b2b_first", 1, 8'h1C, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
        check_frames("b2b_second", 2, 8'hE0, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0,
                     1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_ext_rel();
        test_ignore_busy();
        test_reset_midframe();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
